// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the EXE stage and the HI/LO multiply-divide unit.
interface hilo_muldiv_if #(
   parameter int W = 32
);
   logic         op_valid;
   logic [2:0]   op;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi_o;
   logic [W-1:0] lo_o;

   modport master (
      output op_valid, op, rs_val, rt_val, flush,
      input  busy, done, hi_o, lo_o
   );

   modport slave (
      input  op_valid, op, rs_val, rt_val, flush,
      output busy, done, hi_o, lo_o
   );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO owner for the EXE stage: MULT/MULTU on a fixed-latency pipe, DIV/DIVU on a
// radix-2 restoring divider, plus MTHI/MTLO.
//   state   | meaning
//   S_IDLE  | accepting ops; MTHI/MTLO complete here in one edge
//   S_MUL   | product held, latency down-counter running
//   S_DIV   | one quotient bit per edge, MSB first
//   S_FIXUP | sign correction and HI/LO write-back
module hilo_muldiv #(
   parameter int W       = 32,
   parameter int MUL_LAT = 1
) (
   input logic           clk,
   input logic           rstn,
   hilo_muldiv_if.slave  bus
);
   localparam int CW = $clog2(W + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

   logic           accept, is_signed;
   logic [2*W-1:0] mul_a, mul_b;
   logic [W-1:0]   rs_abs, rt_abs;
   logic [W:0]     shift, trial;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;

      accept    = (state_q == S_IDLE) && bus.op_valid && !bus.flush &&
                  (bus.op >= OP_MULT) && (bus.op <= OP_MTLO);
      is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      mul_a     = {{W{is_signed & bus.rs_val[W-1]}}, bus.rs_val};
      mul_b     = {{W{is_signed & bus.rt_val[W-1]}}, bus.rt_val};
      rs_abs    = (is_signed && bus.rs_val[W-1]) ? -bus.rs_val : bus.rs_val;
      rt_abs    = (is_signed && bus.rt_val[W-1]) ? -bus.rt_val : bus.rt_val;

      // Partial remainder never reaches 2*divisor, so the top bit of the W+1-bit
      // difference is exactly the borrow.
      shift = {rem_q, quo_q[W-1]};
      trial = shift - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MTHI: begin
                     hi_d   = bus.rs_val;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = bus.rs_val;
                     done_d = 1'b1;
                  end
                  OP_MULT, OP_MULTU: begin
                     prod_d  = mul_a * mul_b;
                     cnt_d   = CW'(MUL_LAT - 1);
                     state_d = S_MUL;
                  end
                  default: begin
                     if (bus.rt_val == '0) begin
                        // Divide by zero: FIXUP writes HI=rs, LO=all ones untouched.
                        rem_d   = bus.rs_val;
                        quo_d   = '1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIXUP;
                     end else begin
                        rem_d   = '0;
                        quo_d   = rs_abs;
                        dvs_d   = rt_abs;
                        qneg_d  = is_signed & (bus.rs_val[W-1] ^ bus.rt_val[W-1]);
                        rneg_d  = is_signed & bus.rs_val[W-1];
                        cnt_d   = CW'(W - 1);
                        state_d = S_DIV;
                     end
                  end
               endcase
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               {hi_d, lo_d} = prod_q;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            quo_d = {quo_q[W-2:0], ~trial[W]};
            rem_d = trial[W] ? shift[W-1:0] : trial[W-1:0];
            if (cnt_q == '0) state_d = S_FIXUP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_FIXUP: begin
            lo_d    = qneg_q ? -quo_q : quo_q;
            hi_d    = rneg_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush beats any write on the same edge.
      if (bus.flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.hi_o = hi_q;
   assign bus.lo_o = lo_q;
endmodule
